// File: rtl/bemicro_cv_nios_cpu_div_pkg.sv
// Shared types and constants for the Nios A-stage divide cell.
// State encoding, default width and the iteration counter width.
package bemicro_cv_nios_cpu_div_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/bemicro_cv_nios_cpu_div_if.sv
// Start/busy/done handshake and operand/result bundle
// for the divide cell.
interface bemicro_cv_nios_cpu_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] A_div_src1;
  logic [DATA_WIDTH-1:0] A_div_src2;
  logic                  A_div_signed;
  logic                  A_div_start;
  logic                  A_div_busy;
  logic                  A_div_done;
  logic [DATA_WIDTH-1:0] A_div_quotient;
  logic [DATA_WIDTH-1:0] A_div_remainder;

  modport master (
    output A_div_src1, A_div_src2,
    output A_div_signed, A_div_start,
    input  A_div_busy, A_div_done,
    input  A_div_quotient, A_div_remainder
  );

  modport slave (
    input  A_div_src1, A_div_src2,
    input  A_div_signed, A_div_start,
    output A_div_busy, A_div_done,
    output A_div_quotient, A_div_remainder
  );
endinterface

// File: rtl/bemicro_cv_nios_cpu_div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module bemicro_cv_nios_cpu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic         q_bit
);
  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted = {rem, bit_in};
    diff    = shifted - {2'b00, dvs};
    q_bit   = ~diff[W+1];
    rem_nxt = q_bit ? diff[W:0] : shifted[W:0];
  end
endmodule

// File: rtl/bemicro_cv_nios_cpu_div_cell.sv
// Iterative radix-2 restoring divider, one quotient bit
// per clock, with signed fixup and divide-by-zero handling.
module bemicro_cv_nios_cpu_div_cell
  import bemicro_cv_nios_cpu_div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input logic clk,
  input logic reset,
  bemicro_cv_nios_cpu_div_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(W);

  div_state_t state, state_nxt;

  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W:0]    rem;
  logic [W-1:0]  orig;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;

  logic [W:0]    rem_nxt;
  logic          q_bit;
  logic          accept;
  logic          last;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] x,
    input logic         s
  );
    return (s && x[W-1]) ? (~x + W'(1)) : x;
  endfunction

  bemicro_cv_nios_cpu_div_step #(.W(W)) u_step (
    .rem     (rem),
    .bit_in  (dvd[W-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign accept = bus.A_div_start &&
                  (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = ITER;
      ITER: if (last)   state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = accept ? ITER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      orig  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      dvd   <= mag(bus.A_div_src1, bus.A_div_signed);
      dvs   <= mag(bus.A_div_src2, bus.A_div_signed);
      rem   <= '0;
      orig  <= bus.A_div_src1;
      neg_q <= bus.A_div_signed &&
               (bus.A_div_src1[W-1] ^ bus.A_div_src2[W-1]);
      neg_r <= bus.A_div_signed && bus.A_div_src1[W-1];
      dz    <= (bus.A_div_src2 == '0);
      cnt   <= '0;
    end else if (state == ITER) begin
      rem <= rem_nxt;
      dvd <= {dvd[W-2:0], q_bit};
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      // Divide-by-zero result overrides any sign fixup
      if (dz) begin
        quo_q <= '1;
        rem_q <= orig;
      end else begin
        quo_q <= neg_q ? (~dvd + W'(1)) : dvd;
        rem_q <= neg_r ? (~rem[W-1:0] + W'(1)) : rem[W-1:0];
      end
    end
  end

  assign bus.A_div_busy      = (state == ITER) || (state == FIX);
  assign bus.A_div_done      = (state == DONE);
  assign bus.A_div_quotient  = quo_q;
  assign bus.A_div_remainder = rem_q;
endmodule

// File: tb/tb_bemicro_cv_nios_cpu_div_cell.sv
// Directed bench for the divide cell: vector table plus
// handshake, back-to-back and reset corner sequences.
module tb_bemicro_cv_nios_cpu_div_cell;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bemicro_cv_nios_cpu_div_if #(.DATA_WIDTH(32)) bus ();

  bemicro_cv_nios_cpu_div_cell #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) bus.A_div_start = 1'b0;
      if (bus.A_div_done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic sgn,
                        output int lat);
    @(negedge clk);
    bus.A_div_src1   = a;
    bus.A_div_src2   = b;
    bus.A_div_signed = sgn;
    bus.A_div_start  = 1'b1;
    @(posedge clk);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int busy_bad;
    int done_seen;

    vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000};
    vecs[5]  = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678};
    vecs[6]  = '{32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[8]  = '{32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE};
    vecs[9]  = '{32'd1000000, 32'd1000, 1'b0, 32'd1000, 32'd0};
    vecs[10] = '{32'd5, 32'd10, 1'b0, 32'd0, 32'd5};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0};
    vecs[12] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF};

    bus.A_div_src1   = '0;
    bus.A_div_src2   = '0;
    bus.A_div_signed = 1'b0;
    bus.A_div_start  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(bus.A_div_busy), 32'd0);
    chk("reset_done", 32'(bus.A_div_done), 32'd0);
    chk("reset_q", bus.A_div_quotient, 32'd0);
    chk("reset_r", bus.A_div_remainder, 32'd0);

    // Latency and busy window on the first unsigned case
    bus.A_div_src1   = 32'd100;
    bus.A_div_src2   = 32'd7;
    bus.A_div_signed = 1'b0;
    bus.A_div_start  = 1'b1;
    @(posedge clk);
    busy_bad = 0;
    done_seen = 0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      bus.A_div_start = 1'b0;
      if (n <= 33 && bus.A_div_busy !== 1'b1) busy_bad++;
      if (n <= 33 && bus.A_div_done !== 1'b0) done_seen++;
      if (n == 34) begin
        chk("lat_done34", 32'(bus.A_div_done), 32'd1);
        chk("lat_busy34", 32'(bus.A_div_busy), 32'd0);
      end
    end
    chk("busy_window", 32'(busy_bad), 32'd0);
    chk("no_early_done", 32'(done_seen), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.A_div_done), 32'd0);
    chk("hold_q", bus.A_div_quotient, 32'd14);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd34);
      chk($sformatf("v%0d_q", i), bus.A_div_quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), bus.A_div_remainder, vecs[i].r);
    end

    // Start during busy must be ignored
    @(negedge clk);
    bus.A_div_src1   = 32'd100;
    bus.A_div_src2   = 32'd7;
    bus.A_div_signed = 1'b0;
    bus.A_div_start  = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.A_div_start = 1'b0;
      if (n == 5) begin
        bus.A_div_src1   = 32'hDEADBEEF;
        bus.A_div_src2   = 32'd3;
        bus.A_div_signed = 1'b1;
        bus.A_div_start  = 1'b1;
      end
      if (bus.A_div_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'd34);
    chk("ign_q", bus.A_div_quotient, 32'd14);
    chk("ign_r", bus.A_div_remainder, 32'd2);

    // Back-to-back: new start in the DONE cycle
    bus.A_div_src1   = 32'hFFFFFFFF;
    bus.A_div_src2   = 32'd1;
    bus.A_div_signed = 1'b0;
    bus.A_div_start  = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.A_div_start = 1'b0;
      if (n == 1) begin
        chk("b2b_busy", 32'(bus.A_div_busy), 32'd1);
        chk("b2b_hold_q", bus.A_div_quotient, 32'd14);
      end
      if (bus.A_div_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("b2b_lat", 32'(lat), 32'd34);
    chk("b2b_q", bus.A_div_quotient, 32'hFFFFFFFF);
    chk("b2b_r", bus.A_div_remainder, 32'd0);

    // Reset at iteration 10 aborts the operation
    @(negedge clk);
    bus.A_div_src1  = 32'd100;
    bus.A_div_src2  = 32'd7;
    bus.A_div_start = 1'b1;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      bus.A_div_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.A_div_busy), 32'd0);
    chk("rst_q", bus.A_div_quotient, 32'd0);
    chk("rst_r", bus.A_div_remainder, 32'd0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.A_div_done !== 1'b0) done_seen++;
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
